// File: rtl/vend_pkg.sv
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared types and constants for the vending sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vend_pkg;

    localparam int c_money_w        = 8;
    localparam int c_max_credit_def = 99;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        VEND    = 3'd2,
        REFUND  = 3'd3,
        ALARM   = 3'd4
    } vend_state_e;

    // Adds two money amounts, clamping at the all-ones value.
    function automatic logic [c_money_w-1:0] sat_add(
        input logic [c_money_w-1:0] a,
        input logic [c_money_w-1:0] b
    );
        logic [c_money_w:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[c_money_w] ? '1 : sum[c_money_w-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/vend_timer.sv
// ============================================================================
//  Module      : vend_timer
//  Description : Loadable down-counter; done flags the last counted cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // A loaded value of N yields done on the Nth ticking cycle.
    assign done = (r_count <= WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/vend_sequencer.sv
// ============================================================================
//  Module      : vend_sequencer
//  Description : Coin-operated vending controller with timeout and alarm hold.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_sequencer
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 30,
    parameter int ALARM_CYCLES   = 3,
    parameter int MAX_CREDIT     = c_max_credit_def
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin_valid,
    input  logic [c_money_w-1:0] coin_value,
    input  logic                 confirm,
    input  logic                 cancel,
    input  logic [c_money_w-1:0] product_price,
    input  logic                 clear_sales,
    output logic [c_money_w-1:0] credit,
    output logic [c_money_w-1:0] change,
    output logic                 change_valid,
    output logic                 dispense,
    output logic                 coin_reject,
    output logic                 alarm,
    output logic [c_money_w-1:0] sales_total,
    output logic [2:0]           state
);

    localparam int c_tmr_max = (TIMEOUT_CYCLES > ALARM_CYCLES) ? TIMEOUT_CYCLES : ALARM_CYCLES;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

    vend_state_e          r_state;
    logic [c_money_w-1:0] r_credit;
    logic [c_money_w-1:0] r_change;
    logic [c_money_w-1:0] r_sales;
    logic                 r_change_valid;
    logic                 r_dispense;
    logic                 r_coin_reject;
    logic                 r_alarm;

    logic [c_money_w:0]   w_coin_sum;
    logic                 w_coin_fits;
    logic                 w_can_vend;
    logic                 w_tmr_load;
    logic [c_tmr_w-1:0]   w_tmr_value;
    logic                 w_tmr_tick;
    logic                 w_tmr_done;

    assign w_coin_sum  = {1'b0, r_credit} + {1'b0, coin_value};
    assign w_coin_fits = (w_coin_sum <= (c_money_w + 1)'(MAX_CREDIT));
    assign w_can_vend  = (product_price != '0) && (r_credit >= product_price);

    // Timer controls mirror the transition priorities of the state register.
    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_value = c_tmr_w'(TIMEOUT_CYCLES);
        w_tmr_tick  = 1'b0;
        case (r_state)
            IDLE: begin
                w_tmr_load = coin_valid && (coin_value != '0);
            end
            COLLECT: begin
                if (cancel) begin
                    w_tmr_load = 1'b0;
                end else if (confirm) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = c_tmr_w'(ALARM_CYCLES);
                end else if (coin_valid) begin
                    w_tmr_load = 1'b1;
                end else begin
                    w_tmr_tick = 1'b1;
                end
            end
            ALARM: begin
                if (cancel) begin
                    w_tmr_load = 1'b0;
                end else if (w_tmr_done) begin
                    w_tmr_load = 1'b1;
                end else begin
                    w_tmr_tick = 1'b1;
                end
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    vend_timer #(
        .WIDTH (c_tmr_w)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_tmr_load),
        .load_value (w_tmr_value),
        .tick       (w_tmr_tick),
        .done       (w_tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_credit       <= '0;
            r_change       <= '0;
            r_sales        <= '0;
            r_change_valid <= 1'b0;
            r_dispense     <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_alarm        <= 1'b0;
        end else begin
            r_change_valid <= 1'b0;
            r_dispense     <= 1'b0;
            r_coin_reject  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (coin_valid) begin
                        if (coin_value != '0) begin
                            r_credit <= coin_value;
                            r_state  <= COLLECT;
                        end else begin
                            r_coin_reject <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (cancel) begin
                        r_coin_reject  <= coin_valid;
                        r_change       <= r_credit;
                        r_change_valid <= 1'b1;
                        r_credit       <= '0;
                        r_state        <= REFUND;
                    end else if (confirm) begin
                        r_coin_reject <= coin_valid;
                        if (w_can_vend) begin
                            r_dispense     <= 1'b1;
                            r_change       <= r_credit - product_price;
                            r_change_valid <= 1'b1;
                            r_sales        <= sat_add(r_sales, product_price);
                            r_credit       <= '0;
                            r_state        <= VEND;
                        end else begin
                            r_alarm <= 1'b1;
                            r_state <= ALARM;
                        end
                    end else if (coin_valid) begin
                        if (w_coin_fits) begin
                            r_credit <= w_coin_sum[c_money_w-1:0];
                        end else begin
                            r_coin_reject <= 1'b1;
                        end
                    end else if (w_tmr_done) begin
                        r_change       <= r_credit;
                        r_change_valid <= 1'b1;
                        r_credit       <= '0;
                        r_state        <= REFUND;
                    end
                end
                VEND: begin
                    r_state <= IDLE;
                end
                REFUND: begin
                    r_state <= IDLE;
                end
                ALARM: begin
                    r_coin_reject <= coin_valid;
                    if (cancel) begin
                        r_alarm        <= 1'b0;
                        r_change       <= r_credit;
                        r_change_valid <= 1'b1;
                        r_credit       <= '0;
                        r_state        <= REFUND;
                    end else if (w_tmr_done) begin
                        r_alarm <= 1'b0;
                        r_state <= COLLECT;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (clear_sales) begin
                r_sales <= '0;
            end
        end
    end

    assign credit       = r_credit;
    assign change       = r_change;
    assign change_valid = r_change_valid;
    assign dispense     = r_dispense;
    assign coin_reject  = r_coin_reject;
    assign alarm        = r_alarm;
    assign sales_total  = r_sales;
    assign state        = r_state;

endmodule

`default_nettype wire
